// File: rtl/serial_mod_n_checker.sv
// serial_mod_n_checker: bit-serial remainder / divisibility engine with a run-time divisor latched per frame.
// Define MOD_LSB_FIRST_EN to add the lsb_first port and LSB-first weighted accumulation.
module serial_mod_n_checker #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIV_W-1:0] divisor,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             last,
`ifdef MOD_LSB_FIRST_EN
    input  logic             lsb_first,
`endif
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] rem,
    output logic             divisible,
    output logic             err,
    output logic [CNT_W-1:0] bit_count
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
    state_t state, next_state;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] next_rem;
    logic [DIV_W:0] msb_sum;
    logic [DIV_W-1:0] msb_red;
    logic div_zero, accept, go_hold;
    assign div_zero = (divisor == '0);
    // start always wins over a bit presented in the same cycle
    assign accept = (state == RUN) && bit_valid && !start;
    assign go_hold = start ? div_zero : (accept && last);
    // rem < D, so 2*rem+bit < 2*D and one conditional subtract suffices
    assign msb_sum = {rem, bit_in};
    assign msb_red = (msb_sum >= {1'b0, div_q}) ? msb_sum[DIV_W-1:0] - div_q : msb_sum[DIV_W-1:0];
`ifdef MOD_LSB_FIRST_EN
    logic lsb_q;
    logic [DIV_W-1:0] w;
    logic [DIV_W:0] lsb_sum, w_dbl;
    logic [DIV_W-1:0] lsb_red, w_red;
    assign lsb_sum = {1'b0, rem} + (bit_in ? {1'b0, w} : '0);
    assign lsb_red = (lsb_sum >= {1'b0, div_q}) ? lsb_sum[DIV_W-1:0] - div_q : lsb_sum[DIV_W-1:0];
    assign w_dbl = {w, 1'b0};
    assign w_red = (w_dbl >= {1'b0, div_q}) ? w_dbl[DIV_W-1:0] - div_q : w_dbl[DIV_W-1:0];
    assign next_rem = lsb_q ? lsb_red : msb_red;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lsb_q <= 1'b0;
            w <= '0;
        end else if (start) begin
            lsb_q <= lsb_first;
            w <= DIV_W'(divisor != DIV_W'(1));
        end else if (accept) begin
            w <= w_red;
        end
    end
`else
    assign next_rem = msb_red;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end
    always_comb begin
        next_state = start ? (div_zero ? HOLD : RUN) : ((accept && last) ? HOLD : state);
    end
    always_comb begin
        busy = (state == RUN);
        divisible = (state != IDLE) && (rem == '0) && !err;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            rem <= '0;
            err <= 1'b0;
            bit_count <= '0;
            done <= 1'b0;
        end else begin
            done <= go_hold;
            if (start) begin
                div_q <= divisor;
                rem <= '0;
                err <= div_zero;
                bit_count <= '0;
            end else if (accept) begin
                rem <= next_rem;
                bit_count <= bit_count + CNT_W'(bit_count != '1);
            end
        end
    end
endmodule

// File: tb/tb_serial_mod_n_checker.sv
// tb_serial_mod_n_checker: directed and random frames against an arithmetic value-mod-D model.
// Define MOD_LSB_FIRST_EN to also exercise LSB-first frames.
module tb_serial_mod_n_checker;
    localparam int DIV_W = 8;
    localparam int CNT_W = 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [DIV_W-1:0] divisor = '0;
    logic bit_valid = 1'b0;
    logic bit_in = 1'b0;
    logic last = 1'b0;
`ifdef MOD_LSB_FIRST_EN
    logic lsb_first = 1'b0;
`endif
    logic busy, done, divisible, err;
    logic [DIV_W-1:0] rem;
    logic [CNT_W-1:0] bit_count;
    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_mod_n_checker #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .divisor(divisor),
        .bit_valid(bit_valid),
        .bit_in(bit_in),
        .last(last),
`ifdef MOD_LSB_FIRST_EN
        .lsb_first(lsb_first),
`endif
        .busy(busy),
        .done(done),
        .rem(rem),
        .divisible(divisible),
        .err(err),
        .bit_count(bit_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic begin_frame(input int d);
        start = 1'b1;
        divisor = DIV_W'(d);
        tick();
        start = 1'b0;
        divisor = DIV_W'($urandom);
    endtask

    task automatic send_bit(input logic b, input logic l);
        bit_valid = 1'b1;
        bit_in = b;
        last = l;
        tick();
        bit_valid = 1'b0;
        last = 1'b0;
    endtask

    // Frame value is bits[n-1:0] in either order; the model is simply value % d.
    task automatic run_frame(input string tag, input int d, input logic [63:0] bits, input int n,
                             input bit lsb, input bit gaps);
        longint unsigned value;
        int exp_rem, exp_cnt;
        value = bits & ((64'd1 << n) - 64'd1);
        exp_rem = int'(value % longint'(d));
        exp_cnt = (n > CNT_MAX) ? CNT_MAX : n;
`ifdef MOD_LSB_FIRST_EN
        lsb_first = lsb;
`endif
        begin_frame(d);
        for (int i = 0; i < n; i++) begin
            if (gaps)
                repeat ($urandom_range(0, 2)) begin
                    bit_in = 1'($urandom);
                    last = 1'($urandom);
                    tick();
                end
            send_bit(lsb ? bits[i] : bits[n-1-i], i == n - 1);
            if (i < n - 1) check({tag, "_busy_run"}, {30'd0, busy, done}, 32'd2);
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rem"}, rem, exp_rem);
        check({tag, "_divisible"}, divisible, exp_rem == 0);
        check({tag, "_count"}, bit_count, exp_cnt);
        check({tag, "_err"}, err, 0);
        send_bit(1'b1, 1'b1);
        check({tag, "_done_width"}, done, 0);
        check({tag, "_hold_rem"}, rem, exp_rem);
    endtask

    initial begin
        logic [63:0] r;
        int d, n;
        bit lsb;
        repeat (2) tick();
        check("reset_outs", {busy, done, divisible, err}, 0);
        check("reset_rem", rem, 0);
        check("reset_count", bit_count, 0);
        rst = 1'b0;
        tick();
        check("idle_outs", {busy, done, divisible, err}, 0);

        run_frame("d5_10", 5, 64'b1010, 4, 1'b0, 1'b0);
        run_frame("d5_13", 5, 64'b1101, 4, 1'b0, 1'b0);
        run_frame("d7_255", 7, 64'hFF, 8, 1'b0, 1'b0);

        begin_frame(0);
        check("dz_err", err, 1);
        check("dz_done", done, 1);
        check("dz_busy", busy, 0);
        check("dz_div", divisible, 0);
        check("dz_rem", rem, 0);
        send_bit(1'b1, 1'b1);
        check("dz_done_width", done, 0);
        check("dz_hold_rem", rem, 0);
        check("dz_hold_err", err, 1);
        begin_frame(3);
        check("dz_clear_err", err, 0);
        check("dz_restart_busy", busy, 1);

        begin_frame(5);
        repeat (3) send_bit(1'b1, 1'b0);
        check("pre_rst_rem", rem, 2);
        #2 rst = 1'b1;
        #1;
        check("async_rst_outs", {busy, done, divisible, err}, 0);
        check("async_rst_rem", rem, 0);
        check("async_rst_count", bit_count, 0);
        tick();
        rst = 1'b0;
        tick();

        begin_frame(6);
        repeat (5) send_bit(1'b1, 1'b0);
        check("abort_pre_rem", rem, 31 % 6);
        check("abort_pre_count", bit_count, 5);
        begin_frame(6);
        check("abort_done", done, 0);
        check("abort_count", bit_count, 0);
        check("abort_busy", busy, 1);
        tick();
        check("abort_no_done", done, 0);

        start = 1'b1;
        divisor = 8'd3;
        bit_valid = 1'b1;
        bit_in = 1'b1;
        tick();
        start = 1'b0;
        bit_valid = 1'b0;
        check("sbv_count", bit_count, 0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        check("sbv_done", done, 1);
        check("sbv_rem", rem, 0);
        check("sbv_count2", bit_count, 2);

        begin_frame(9);
        repeat (6) tick();
        check("empty_busy_done", {busy, done}, 2'b10);

        r = {$urandom, $urandom};
        run_frame("d1", 1, r, 20, 1'b0, 1'b1);
        run_frame("dmax", 255, 64'hFFFF_FFFF_FF, 40, 1'b0, 1'b0);
        r = {$urandom, $urandom};
        run_frame("sat", 201, r, 45, 1'b0, 1'b1);

`ifdef MOD_LSB_FIRST_EN
        run_frame("lsb_9", 5, 64'b1001, 4, 1'b1, 1'b0);
        run_frame("msb_9", 5, 64'b1001, 4, 1'b0, 1'b0);
        run_frame("lsb_6", 5, 64'b110, 3, 1'b1, 1'b0);
        run_frame("lsb_d1", 1, 64'b1011, 4, 1'b1, 1'b1);
`endif
        for (int k = 0; k < 16; k++) begin
            r = {$urandom, $urandom};
            d = $urandom_range(1, 255);
            n = $urandom_range(1, 45);
            lsb = 1'b0;
`ifdef MOD_LSB_FIRST_EN
            lsb = 1'($urandom);
`endif
            run_frame("rand", d, r, n, lsb, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_mod_n_checker.md
Name: serial_mod_n_checker

Overview:
- Bit-serial divisibility checker/remainder engine; parametrised successor to the fixed divide-by-five FSM.
- Divisor is supplied at run time, up to DIV_W bits, and latched per frame.
- Consumes an arbitrary-length frame one bit per accepted cycle and reports remainder, divisible flag and bit count.
- Sits behind the pin-mux wrapper: serial bits from ui_in, results to uo_out/uio_out.

Parameters:
- DIV_W, 8: divisor and remainder width in bits (2..16).
- CNT_W, 16: width of the frame bit counter; the counter saturates at its maximum.

Ports:
- clk, input, 1: the single clock; all state on rising edge.
- rst, input, 1: asynchronous active-high reset.
- start, input, 1: begin a new frame; latches divisor.
- divisor, input, DIV_W: modulus; sampled only when start=1.
- bit_valid, input, 1: bit_in is valid this cycle.
- bit_in, input, 1: serial data bit.
- last, input, 1: qualifies bit_valid as the final bit of the frame.
- busy, output, 1: high in RUN.
- done, output, 1: one-cycle pulse when a frame completes.
- rem, output, DIV_W: remainder of the frame value mod the latched divisor.
- divisible, output, 1: (rem==0) && !err.
- err, output, 1: divisor was zero at start.
- bit_count, output, CNT_W: bits accepted in the current/last frame, saturating.

Behaviour:
- Reset (asynchronous, any time including mid-frame):
  - state=IDLE.
  - busy=0, done=0, rem=0, divisible=0, err=0, bit_count=0.
  - Latched divisor=0.
- FSM states: IDLE, RUN, HOLD.
  - IDLE: outputs static.
  - start=1 with divisor!=0 -> RUN. Clear rem, bit_count and err; latch divisor.
  - start=1 with divisor==0 -> HOLD. Set err=1, rem=0, divisible=0, and pulse done next cycle.
  - RUN, bit_valid=1: rem <= (2*rem + bit_in) mod D, computed as a DIV_W+1-bit sum with one conditional subtract of D (legal because rem<D). bit_count increments and saturates at 2^CNT_W-1.
  - RUN, bit_valid=1 and last=1: the bit is processed as above, then -> HOLD with done=1 in the following cycle. This gives 1-cycle latency from the last bit to done; rem/divisible are valid when done=1.
  - RUN, bit_valid=0: hold. last without bit_valid is ignored.
  - HOLD: results stable until the next start; bit_valid is ignored.
  - HOLD, start=1: same transitions as start in IDLE.
- Simultaneous events:
  - start with bit_valid in any state: start wins and the bit is discarded.
  - start during RUN: the current frame is aborted, no done pulse, and a new frame begins.
- D=1: rem stays 0, so divisible=1 after any frame.
- Empty frame (start, then HOLD is never reached): busy stays 1 and there is no timeout.
- divisible is combinational from registered rem/err.
- The done pulse is exactly 1 cycle wide.

Optional Feature:
- Macro: MOD_LSB_FIRST_EN.
- With the macro defined:
  - Extra input lsb_first (1 bit), sampled at start and held for the frame.
  - When lsb_first=1, a weight register w (reset to 1 mod D at start) is maintained. Each accepted bit does rem <= (rem + bit_in*w) mod D and w <= (2*w) mod D, each with one conditional subtract.
  - When lsb_first=0, behaviour is identical to MSB-first.
- Without the macro: the port and the weight register are absent, and MSB-first is the only mode.

Test Plan:
- D=5, bits 1,0,1,0 MSB-first (value 10), last on the 4th bit -> done 1 cycle later, rem=0, divisible=1, bit_count=4.
- D=5, bits 1,1,0,1 (13) -> rem=3, divisible=0. Then D=7, eight 1s (255) -> rem=3, bit_count=8.
- start with D=0 -> err=1, divisible=0, done pulse, busy=0. Next start with D=3 clears err.
- Mid-frame: assert rst after 3 bits -> all outputs 0 asynchronously. Separately, start during RUN after 5 bits of 1s with D=6 -> no done pulse, bit_count restarts at 0.
- start and bit_valid in the same cycle, then bits 1,1 (3) with D=3 -> the first bit is ignored, rem=0. Gaps in bit_valid do not alter the result.
- With MOD_LSB_FIRST_EN: lsb_first=1, D=5, bits 1,0,0,1 LSB-first (9) -> rem=4. Same bits with lsb_first=0 (value 9 MSB-first: 1001) -> rem=4. Bits 0,1,1 with lsb_first=1 (6) -> rem=1.
